// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS32 multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, followed by
// a sign-correction cycle that commits HI/LO.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             useMDD,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallMD
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_SIGN = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;        // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opb;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;      // original rs, returned as HI on divide by zero
  logic               is_div, neg_q, neg_r, dz;

  logic               start_ok, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand conditioning, one iteration step and final sign correction
  always_comb begin
    start_ok  = startE && (opE[2] == 1'b0);
    signed_op = ~opE[0];
    a_neg     = signed_op & srcAE[WIDTH-1];
    b_neg     = signed_op & srcBE[WIDTH-1];
    abs_a     = a_neg ? -srcAE : srcAE;
    abs_b     = b_neg ? -srcBE : srcBE;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_sh - {1'b0, opb};
    prod      = neg_q ? -acc : acc;
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (dz) begin
      res_hi = a_raw;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = opE[1] ? S_DIV : S_MUL;
      S_MUL:  if (cnt == '0) state_nxt = S_SIGN;
      S_DIV:  if (cnt == '0) state_nxt = S_SIGN;
      S_SIGN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath, HI/LO and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            cnt    <= CNT_W'(WIDTH - 1);
            busy   <= 1'b1;
            is_div <= opE[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            a_raw  <= srcAE;
            dz     <= (srcBE == '0);
            if (opE[1]) begin
              acc <= {{WIDTH{1'b0}}, abs_a};
              opb <= abs_b;
            end else begin
              acc <= {{WIDTH{1'b0}}, abs_b};
              opb <= abs_a;
            end
          end else if (startE && opE == 3'b100) begin
            hi <= srcAE;
          end else if (startE && opE == 3'b101) begin
            lo <= srcAE;
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_DIV: begin
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                  acc <= {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_SIGN: begin
          hi   <= res_hi;
          lo   <= res_lo;
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  assign stallMD = busy & useMDD;

endmodule
